// File: rtl/kanal_tarama_mux.sv
// Registered N:1 word multiplexer with a valid/ready output stage and a
// round-robin scan mode that steps through an enabled-channel mask.
module kanal_tarama_mux #(
    parameter int W = 32,
    parameter int N = 16,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N-1:0]      chan_en,
    input  logic              scan_clr,
    input  logic [N*W-1:0]    din,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   dout_ch,
    output logic              scan_wrap,
    output logic              out_valid,
    input  logic              out_ready
);

    // Handshake: a word moves on any rising edge where valid && ready are both
    // high; a producer holds valid and its payload until that edge, and ready
    // never depends combinationally on the same-side valid.

    logic [W-1:0]    chan_w [N];
    logic [SELW-1:0] scan_ptr;
    logic [SELW-1:0] scan_ch;
    logic [SELW-1:0] ch;
    logic [SELW-1:0] nxt;
    logic            scan_hit;
    logic            nxt_hit;
    logic            accept;

    for (genvar k = 0; k < N; k++) begin : g_split
        assign chan_w[k] = din[k*W +: W];
    end

    // Cyclic priority search: first enabled channel at or after scan_ptr.
    always_comb begin
        scan_ch  = scan_ptr;
        scan_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!scan_hit && chan_en[scan_ptr + SELW'(i)]) begin
                scan_ch  = scan_ptr + SELW'(i);
                scan_hit = 1'b1;
            end
        end
    end

    assign ch = mode ? scan_ch : sel;

    // First enabled channel strictly after ch; the last step lands back on ch,
    // so a single enabled channel yields nxt == ch.
    always_comb begin
        nxt     = ch;
        nxt_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!nxt_hit && chan_en[ch + SELW'(i + 1)]) begin
                nxt     = ch + SELW'(i + 1);
                nxt_hit = 1'b1;
            end
        end
    end

    assign in_ready = (!out_valid || out_ready) && !(mode && (chan_en == '0));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_ch   <= '0;
            scan_wrap <= 1'b0;
            scan_ptr  <= '0;
        end else begin
            if (accept) begin
                // A disabled channel selected in fixed mode still transfers, as zero.
                dout      <= chan_en[ch] ? chan_w[ch] : '0;
                dout_ch   <= ch;
                scan_wrap <= mode && (nxt <= ch);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (scan_clr) begin
                scan_ptr <= '0;
            end else if (accept && mode) begin
                scan_ptr <= nxt;
            end
        end
    end

endmodule
